// File: rtl/reg_writeback.sv
// reg_writeback: register-file write-port driver.
// Merges single-cycle ALU results with buffered load results into one
// registered write per cycle, and tracks outstanding loads in a 32-entry
// pending scoreboard that decode queries for stalls.
// Optional feature macro: WB_BYPASS_EN adds rs_fwd_out/rt_fwd_out, which flag
// a same-cycle match against the in-flight register-file write.
module reg_writeback #(
    parameter int unsigned LD_DEPTH = 4,
    parameter int unsigned LD_AW    = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        stall_in,
    input  logic        alu_valid_in,
    input  logic [4:0]  alu_rd_in,
    input  logic [31:0] alu_data_in,
    input  logic        ld_valid_in,
    output logic        ld_ready_out,
    input  logic [4:0]  ld_rd_in,
    input  logic [31:0] ld_data_in,
    input  logic        iss_valid_in,
    input  logic [4:0]  iss_rd_in,
    input  logic [4:0]  rs_in,
    input  logic [4:0]  rt_in,
    output logic        rs_busy_out,
    output logic        rt_busy_out,
`ifdef WB_BYPASS_EN
    output logic        rs_fwd_out,
    output logic        rt_fwd_out,
`endif
    output logic        we_out,
    output logic [4:0]  rd_out,
    output logic [31:0] write_data_out
);

    localparam int unsigned CW = LD_AW + 1;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } ld_entry_t;

    ld_entry_t        fifo_mem [LD_DEPTH];
    logic [LD_AW-1:0] wr_ptr;
    logic [LD_AW-1:0] rd_ptr;
    logic [CW-1:0]    count;
    logic [31:0]      pending;
    logic [31:0]      pending_nxt;
    ld_entry_t        head;
    logic             push;
    logic             pop;

    // FIFO handshake: no push-through when full; ALU always wins the write port
    always_comb begin
        ld_ready_out = (count < CW'(LD_DEPTH));
        push         = ld_valid_in && ld_ready_out;
        pop          = !stall_in && !alu_valid_in && (count != '0);
        head         = fifo_mem[rd_ptr];
    end

    // Scoreboard next state: clear for last cycle's write, then set (set wins)
    always_comb begin
        pending_nxt = pending;
        if (we_out) begin
            pending_nxt[rd_out] = 1'b0;
        end
        if (iss_valid_in && !stall_in && (iss_rd_in != 5'd0)) begin
            pending_nxt[iss_rd_in] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

`ifdef WB_BYPASS_EN
    // Forward flags match the write in flight; a forwarded source is not busy
    always_comb begin
        rs_fwd_out  = we_out && (rd_out == rs_in) && (rs_in != 5'd0);
        rt_fwd_out  = we_out && (rd_out == rt_in) && (rt_in != 5'd0);
        rs_busy_out = pending[rs_in] && !rs_fwd_out;
        rt_busy_out = pending[rt_in] && !rt_fwd_out;
    end
`else
    // Busy lookups straight from the scoreboard
    always_comb begin
        rs_busy_out = pending[rs_in];
        rt_busy_out = pending[rt_in];
    end
`endif

    // Load-result storage; contents are don't-care once popped or reset
    always_ff @(posedge clk_in) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{rd: ld_rd_in, data: ld_data_in};
        end
    end

    // Pointers, occupancy, scoreboard and registered write port
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            pending        <= '0;
            we_out         <= 1'b0;
            rd_out         <= 5'd0;
            write_data_out <= 32'd0;
        end else begin
            pending <= pending_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + LD_AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + LD_AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);

            if (stall_in) begin
                we_out <= 1'b0;
            end else if (alu_valid_in) begin
                we_out         <= (alu_rd_in != 5'd0);
                rd_out         <= alu_rd_in;
                write_data_out <= alu_data_in;
            end else if (count != '0) begin
                we_out         <= (head.rd != 5'd0);
                rd_out         <= head.rd;
                write_data_out <= head.data;
            end else begin
                we_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_reg_writeback.sv
// tb_reg_writeback: directed plan steps followed by random traffic, checked
// against a queue/array reference model of the write-back rules.
module tb_reg_writeback;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, stall, alu_v, ld_v, iss_v;
    logic [4:0]  alu_rd, ld_rd, iss_rd, rs, rt;
    logic [31:0] alu_d, ld_d;
    logic        ld_ready, rs_busy, rt_busy, we;
    logic [4:0]  rd;
    logic [31:0] wdata;
`ifdef WB_BYPASS_EN
    logic        rs_fwd, rt_fwd;
`endif

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] d;
    } ent_t;

    // Reference model state
    ent_t        m_q[$];
    bit   [31:0] m_pend;
    logic        m_we;
    logic [4:0]  m_rd;
    logic [31:0] m_data;

    always #5 clk = ~clk;

    reg_writeback #(.LD_DEPTH(DEPTH), .LD_AW(2)) dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .stall_in       (stall),
        .alu_valid_in   (alu_v),
        .alu_rd_in      (alu_rd),
        .alu_data_in    (alu_d),
        .ld_valid_in    (ld_v),
        .ld_ready_out   (ld_ready),
        .ld_rd_in       (ld_rd),
        .ld_data_in     (ld_d),
        .iss_valid_in   (iss_v),
        .iss_rd_in      (iss_rd),
        .rs_in          (rs),
        .rt_in          (rt),
        .rs_busy_out    (rs_busy),
        .rt_busy_out    (rt_busy),
`ifdef WB_BYPASS_EN
        .rs_fwd_out     (rs_fwd),
        .rt_fwd_out     (rt_fwd),
`endif
        .we_out         (we),
        .rd_out         (rd),
        .write_data_out (wdata)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rst = 0; stall = 0; alu_v = 0; ld_v = 0; iss_v = 0;
        alu_rd = 0; alu_d = 0; ld_rd = 0; ld_d = 0; iss_rd = 0;
    endtask

    function automatic logic exp_busy(input logic [4:0] src);
        logic b;
        b = m_pend[src];
`ifdef WB_BYPASS_EN
        if (m_we && m_rd == src && src != 0) b = 1'b0;
`endif
        return b;
    endfunction

    // One clock: check combinational outputs, advance the model, check the write port
    task automatic tick();
        bit   acc;
        ent_t e;
        #1;
        chk("ld_ready", ld_ready, (m_q.size() < DEPTH));
        chk("rs_busy", rs_busy, exp_busy(rs));
        chk("rt_busy", rt_busy, exp_busy(rt));
`ifdef WB_BYPASS_EN
        chk("rs_fwd", rs_fwd, m_we && m_rd == rs && rs != 0);
        chk("rt_fwd", rt_fwd, m_we && m_rd == rt && rt != 0);
`endif
        if (rst) begin
            m_q.delete();
            m_pend = '0;
            m_we = 0; m_rd = 0; m_data = 0;
        end else begin
            acc = ld_v && (m_q.size() < DEPTH);
            if (m_we) m_pend[m_rd] = 1'b0;
            if (iss_v && !stall && iss_rd != 0) m_pend[iss_rd] = 1'b1;
            if (stall) begin
                m_we = 0;
            end else if (alu_v) begin
                m_we = (alu_rd != 0); m_rd = alu_rd; m_data = alu_d;
            end else if (m_q.size() > 0) begin
                e = m_q.pop_front();
                m_we = (e.rd != 0); m_rd = e.rd; m_data = e.d;
            end else begin
                m_we = 0;
            end
            if (acc) m_q.push_back('{rd: ld_rd, d: ld_d});
        end
        @(posedge clk);
        #1;
        chk("we", we, m_we);
        chk("rd", rd, m_rd);
        chk("wdata", wdata, m_data);
    endtask

    initial begin
        idle();
        rs = 0; rt = 0;
        m_pend = '0; m_we = 0; m_rd = 0; m_data = 0;
        @(posedge clk);
        #1;

        // Reset
        rst = 1; tick(); idle();
        chk("reset_ready", ld_ready, 1'b1);

        // ALU write then idle
        alu_v = 1; alu_rd = 5; alu_d = 32'h1234; tick(); idle();
        chk("alu_we_direct", we, 1'b1);
        chk("alu_data_direct", wdata, 32'h1234);
        tick();

        // $0 suppression for ALU and load
        alu_v = 1; alu_rd = 0; alu_d = 32'hFFFF; tick(); idle();
        chk("alu_r0_we", we, 1'b0);
        ld_v = 1; ld_rd = 0; ld_d = 32'h55; tick(); idle();
        tick();
        tick();

        // Arbitration: load buffered under stall, then three ALU writes, then the load
        stall = 1; ld_v = 1; ld_rd = 7; ld_d = 32'hAA; tick(); idle();
        for (int i = 1; i <= 3; i++) begin
            alu_v = 1; alu_rd = 5'(i); alu_d = 32'(i * 16); tick();
        end
        idle(); tick();
        chk("arb_load_rd", rd, 5'd7);
        chk("arb_load_data", wdata, 32'hAA);

        // Fill FIFO under ALU traffic, reject a fifth while popping, drain in order
        for (int i = 0; i < 4; i++) begin
            alu_v = 1; alu_rd = 5'(20 + i); alu_d = 32'(i);
            ld_v = 1; ld_rd = 5'(10 + i); ld_d = 32'(32'hC0 + i); tick();
        end
        idle();
        ld_v = 1; ld_rd = 5'd14; ld_d = 32'hDEAD; tick(); idle();
        for (int i = 0; i < 5; i++) tick();

        // Scoreboard set, load completion, clear timing, set-in-clear-cycle
        rs = 9; rt = 3;
        iss_v = 1; iss_rd = 9; tick(); idle();
        ld_v = 1; ld_rd = 9; ld_d = 32'h99; tick(); idle();
        tick();
        tick();
        tick();
        iss_v = 1; iss_rd = 9; tick(); idle();
        ld_v = 1; ld_rd = 9; ld_d = 32'h98; tick(); idle();
        tick();
        iss_v = 1; iss_rd = 9; tick(); idle();
        tick();
        chk("set_wins_busy", rs_busy, 1'b1);

        // Stall with FIFO non-empty, push during stall, then reset mid-drain
        for (int i = 0; i < 2; i++) begin
            alu_v = 1; alu_rd = 5'(4 + i); alu_d = 32'(i);
            ld_v = 1; ld_rd = 5'(16 + i); ld_d = 32'(32'hE0 + i); tick();
        end
        idle();
        stall = 1; ld_v = 1; ld_rd = 18; ld_d = 32'hE2; iss_v = 1; iss_rd = 3; tick();
        ld_v = 0; iss_v = 0; tick(); idle();
        tick();
        rst = 1; tick(); idle();
        tick();
        chk("post_reset_busy", rs_busy, 1'b0);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            rst    = ($urandom_range(0, 79) == 0);
            stall  = ($urandom_range(0, 3) == 0);
            alu_v  = ($urandom_range(0, 2) == 0);
            alu_rd = 5'($urandom_range(0, 31));
            if (m_pend[alu_rd]) alu_rd = 0;
            alu_d  = $urandom;
            ld_v   = ($urandom_range(0, 1) == 0);
            ld_rd  = 5'($urandom_range(0, 31));
            ld_d   = $urandom;
            iss_v  = ($urandom_range(0, 2) == 0);
            iss_rd = 5'($urandom_range(0, 31));
            rs     = 5'($urandom_range(0, 31));
            rt     = 5'($urandom_range(0, 31));
            tick();
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
